cascade_cache_ctrl: RTL and testbench

CASCADE_CACHE_CTRL -- requirements
Module: cascade_cache_ctrl

---
 rtl/cascade_cache_ctrl.sv | 143 ++++++++++++++
 tb/tb_cascade_cache_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_cache_ctrl.sv
// cascade_cache_ctrl: burst loader plus two-port round-robin read arbiter
// in front of a single-ported cache with a registered read address.
// Optional feature: define CASCADE_CACHE_CTRL_READ_DURING_LOAD_EN to allow
// reads while a burst is loading. A read to the address being written in
// that same cycle is held off.
module cascade_cache_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_SIZE  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_start_i,
    input  logic [ADDR_WIDTH-1:0] load_base_i,
    input  logic [ADDR_WIDTH:0]   load_len_i,
    output logic                  load_busy_o,
    output logic                  load_done_o,
    input  logic                  wr_valid_i,
    input  logic [WORD_SIZE-1:0]  wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  rd0_req_i,
    input  logic [ADDR_WIDTH-1:0] rd0_addr_i,
    output logic                  rd0_gnt_o,
    output logic                  rd0_valid_o,
    output logic [WORD_SIZE-1:0]  rd0_data_o,
    input  logic                  rd1_req_i,
    input  logic [ADDR_WIDTH-1:0] rd1_addr_i,
    output logic                  rd1_gnt_o,
    output logic                  rd1_valid_o,
    output logic [WORD_SIZE-1:0]  rd1_data_o,
    output logic                  cc_we_o,
    output logic [ADDR_WIDTH-1:0] cc_waddr_o,
    output logic [WORD_SIZE-1:0]  cc_wdata_o,
    output logic [ADDR_WIDTH-1:0] cc_raddr_o,
    input  logic [WORD_SIZE-1:0]  cc_q_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q, cnt_q, cnt_inc;
    logic                  rr_q;        // 0: rd0 wins a tie, 1: rd1 wins a tie
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  vld0_q, vld1_q;
    logic                  xfer, rd_allow, elig0, elig1;

    assign xfer    = (state_q == LOAD) && wr_valid_i;
    assign cnt_inc = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; load_start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start_i) state_d = (load_len_i == '0) ? DONE : LOAD;
            LOAD:    if (xfer && (cnt_inc == len_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Burst bookkeeping: latch base/length on start, count accepted words
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == IDLE && load_start_i) begin
            base_q <= load_base_i;
            len_q  <= load_len_i;
            cnt_q  <= '0;
        end else if (xfer) begin
            cnt_q  <= cnt_inc;
        end
    end

    // FSM outputs; write data/address are forced to zero when not loading
    always_comb begin
        load_busy_o = 1'b0;
        load_done_o = 1'b0;
        wr_ready_o  = 1'b0;
        cc_we_o     = 1'b0;
        cc_waddr_o  = '0;
        cc_wdata_o  = '0;
        case (state_q)
            LOAD: begin
                load_busy_o = 1'b1;
                wr_ready_o  = 1'b1;
                cc_we_o     = wr_valid_i;
                cc_waddr_o  = base_q + cnt_q[ADDR_WIDTH-1:0];
                cc_wdata_o  = wr_valid_i ? wr_data_i : '0;
            end
            DONE: begin
                load_busy_o = 1'b1;
                load_done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Read eligibility: which states may grant, and the same-address write hazard
    always_comb begin
`ifdef CASCADE_CACHE_CTRL_READ_DURING_LOAD_EN
        rd_allow = (state_q == IDLE) || (state_q == LOAD);
        elig0    = rd_allow && rd0_req_i && !(cc_we_o && (rd0_addr_i == cc_waddr_o));
        elig1    = rd_allow && rd1_req_i && !(cc_we_o && (rd1_addr_i == cc_waddr_o));
`else
        rd_allow = (state_q == IDLE);
        elig0    = rd_allow && rd0_req_i;
        elig1    = rd_allow && rd1_req_i;
`endif
    end

    assign rd0_gnt_o  = elig0 && (!elig1 || !rr_q);
    assign rd1_gnt_o  = elig1 && (!elig0 || rr_q);
    assign cc_raddr_o = rd0_gnt_o ? rd0_addr_i : (rd1_gnt_o ? rd1_addr_i : raddr_q);
    assign rd0_data_o = vld0_q ? cc_q_i : '0;
    assign rd1_data_o = vld1_q ? cc_q_i : '0;
    assign rd0_valid_o = vld0_q;
    assign rd1_valid_o = vld1_q;

    // Arbiter state: tie pointer flips to the loser, read address holds, valid trails grant
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= 1'b0;
            raddr_q <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            if (rd0_gnt_o)      rr_q <= 1'b1;
            else if (rd1_gnt_o) rr_q <= 1'b0;
            raddr_q <= cc_raddr_o;
            vld0_q  <= rd0_gnt_o;
            vld1_q  <= rd1_gnt_o;
        end
    end

endmodule

// File: tb/tb_cascade_cache_ctrl.sv
// Directed bench for cascade_cache_ctrl with a queue-based scoreboard.
// Stimulus pushes expected writes, read returns and done pulses; a monitor
// on the falling edge pops and compares whenever the DUT shows one.
module tb_cascade_cache_ctrl;

    localparam int AW = 10;
    localparam int WS = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic          load_busy, load_done;
    logic          wr_valid = 1'b0;
    logic [WS-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd0_req = 1'b0, rd1_req = 1'b0;
    logic [AW-1:0] rd0_addr = '0, rd1_addr = '0;
    logic          rd0_gnt, rd1_gnt, rd0_valid, rd1_valid;
    logic [WS-1:0] rd0_data, rd1_data;
    logic          cc_we;
    logic [AW-1:0] cc_waddr, cc_raddr;
    logic [WS-1:0] cc_wdata;
    logic [WS-1:0] cc_q = '0;

    cascade_cache_ctrl #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .load_start_i(load_start), .load_base_i(load_base), .load_len_i(load_len),
        .load_busy_o(load_busy), .load_done_o(load_done),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .rd0_req_i(rd0_req), .rd0_addr_i(rd0_addr), .rd0_gnt_o(rd0_gnt),
        .rd0_valid_o(rd0_valid), .rd0_data_o(rd0_data),
        .rd1_req_i(rd1_req), .rd1_addr_i(rd1_addr), .rd1_gnt_o(rd1_gnt),
        .rd1_valid_o(rd1_valid), .rd1_data_o(rd1_data),
        .cc_we_o(cc_we), .cc_waddr_o(cc_waddr), .cc_wdata_o(cc_wdata),
        .cc_raddr_o(cc_raddr), .cc_q_i(cc_q)
    );

    always #5 clk = ~clk;

    // Cache model: unwritten locations read back as D000_0000 | addr
    logic [WS-1:0] mem [1024];
    bit            wrote [1024];
    always @(posedge clk) begin
        if (cc_we) begin
            mem[cc_waddr]   <= cc_wdata;
            wrote[cc_waddr] <= 1'b1;
        end
        cc_q <= wrote[cc_raddr] ? mem[cc_raddr] : (32'hD000_0000 | {22'b0, cc_raddr});
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t wq[$], r0q[$], r1q[$], dq[$];
    int  n_chk = 0;
    int  n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t e, input logic [31:0] a, input logic [31:0] d);
        n_chk++;
        if (e.c != cyc || e.a !== a || e.d !== d) begin
            n_fail++;
            $display("FAIL %s: got cyc %0d addr %0h data %0h expected cyc %0d addr %0h data %0h",
                     nm, cyc, a, d, e.c, e.a, e.d);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
    endtask

    // Monitor: compare every DUT-presented event against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (cc_we) begin
                if (wq.size() == 0) unexpected("write");
                else cmp_ev("write", wq.pop_front(), {22'b0, cc_waddr}, cc_wdata);
            end
            if (rd0_valid) begin
                if (r0q.size() == 0) unexpected("rd0_valid");
                else cmp_ev("rd0_ret", r0q.pop_front(), 32'h0, rd0_data);
            end
            if (rd1_valid) begin
                if (r1q.size() == 0) unexpected("rd1_valid");
                else cmp_ev("rd1_ret", r1q.pop_front(), 32'h0, rd1_data);
            end
            if (load_done) begin
                if (dq.size() == 0) unexpected("load_done");
                else cmp_ev("load_done", dq.pop_front(), 32'h0, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_w(input logic [AW-1:0] a, input logic [WS-1:0] d);
        ev_t e;
        e.c = cyc; e.a = {22'b0, a}; e.d = d;
        wq.push_back(e);
    endtask

    task automatic push_d(input int c);
        ev_t e;
        e.c = c; e.a = '0; e.d = '0;
        dq.push_back(e);
    endtask

    task automatic push_r(input int which, input logic [WS-1:0] d);
        ev_t e;
        e.c = cyc + 1; e.a = '0; e.d = d;
        if (which == 0) r0q.push_back(e);
        else            r1q.push_back(e);
    endtask

    function automatic logic [255:0] all_outs();
        return {load_busy, load_done, wr_ready, rd0_gnt, rd0_valid, rd0_data,
                rd1_gnt, rd1_valid, rd1_data, cc_we, cc_waddr, cc_wdata, cc_raddr};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ad [4];
        logic [WS-1:0] wd [4];
        ad = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        wd = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};

        // Reset state
        #12;
        chk("reset_outs", all_outs(), '0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_outs", all_outs(), '0);

        // Wrapping burst of 4 with continuous valid
        tick();
        load_start = 1'b1; load_base = 10'h3FE; load_len = 11'd4;
        tick();
        load_start = 1'b0;
        push_d(cyc + 4);
        for (int k = 0; k < 4; k++) begin
            wr_valid = 1'b1; wr_data = wd[k];
            push_w(ad[k], wd[k]);
            @(negedge clk);
            if (k == 0) chk("load_ready_busy", {wr_ready, load_busy}, 2'b11);
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wrap_done_busy", {load_done, load_busy}, 2'b11);
        tick();
        @(negedge clk);
        chk("wrap_busy_fall", {load_done, load_busy}, 2'b00);

        // Zero-length burst: done next cycle, never a write
        tick();
        load_start = 1'b1; load_base = 10'h055; load_len = 11'd0;
        push_d(cyc + 1);
        tick();
        load_start = 1'b0;
        @(negedge clk);
        chk("len0_done", {load_done, load_busy, cc_we}, 3'b110);
        tick();
        @(negedge clk);
        chk("len0_idle", load_busy, 1'b0);

        // Both requesters continuously in IDLE: alternate rd0, rd1, ...
        tick();
        rd0_req = 1'b1; rd0_addr = 10'h010;
        rd1_req = 1'b1; rd1_addr = 10'h020;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_gnt", {rd0_gnt, rd1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i % 2 == 0) push_r(0, 32'hD000_0010);
            else            push_r(1, 32'hD000_0020);
            tick();
        end
        rd0_req = 1'b0; rd1_req = 1'b0;
        @(negedge clk);
        chk("no_gnt_hold_raddr", {rd0_gnt, rd1_gnt, cc_raddr}, {2'b00, 10'h020});

        // Burst of 3 with toggling valid and a mid-burst load_start
        tick();
        load_start = 1'b1; load_base = 10'h100; load_len = 11'd3;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h1111_0000; push_w(10'h100, 32'h1111_0000);
        tick();
        wr_valid = 1'b0;
        load_start = 1'b1; load_base = 10'h300; load_len = 11'd1;
        @(negedge clk);
        chk("toggle_not_ready_idle", {wr_ready, cc_we}, 2'b10);
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h1111_0001; push_w(10'h101, 32'h1111_0001);
        tick();
        wr_valid = 1'b0;
        tick();
        wr_valid = 1'b1; wr_data = 32'h1111_0002; push_w(10'h102, 32'h1111_0002);
        push_d(cyc + 1);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("toggle_done", load_done, 1'b1);
        tick();
        @(negedge clk);
        chk("toggle_idle", {load_busy, wr_ready}, 2'b00);

        // Reset after 2 of 5 words aborts the burst
        tick();
        load_start = 1'b1; load_base = 10'h200; load_len = 11'd5;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h2222_0000; push_w(10'h200, 32'h2222_0000);
        tick();
        wr_data = 32'h2222_0001; push_w(10'h201, 32'h2222_0001);
        tick();
        wr_data = 32'h2222_0002;
        rst_n = 1'b0;
        #1;
        chk("abort_outs_zero", all_outs(), '0);
        wr_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        load_start = 1'b1; load_base = 10'h005; load_len = 11'd2;
        tick();
        load_start = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h3333_0000; push_w(10'h005, 32'h3333_0000);
        tick();
        wr_data = 32'h3333_0001; push_w(10'h006, 32'h3333_0001);
        push_d(cyc + 1);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_done", {load_done, load_busy}, 2'b11);
        tick();

        // Read against the in-flight write address during LOAD
        tick();
        load_start = 1'b1; load_base = 10'h040; load_len = 11'd3;
        tick();
        load_start = 1'b0;
        push_d(cyc + 3);
        wr_valid = 1'b1; wr_data = 32'h4444_0000; push_w(10'h040, 32'h4444_0000);
        rd0_req = 1'b1; rd0_addr = 10'h040;
        @(negedge clk);
        chk("rdl_same_addr_gnt", rd0_gnt, 1'b0);
        tick();
        wr_data = 32'h4444_0001; push_w(10'h041, 32'h4444_0001);
        @(negedge clk);
`ifdef CASCADE_CACHE_CTRL_READ_DURING_LOAD_EN
        chk("rdl_diff_addr_gnt", rd0_gnt, 1'b1);
        push_r(0, 32'h4444_0000);
        tick();
        rd0_req = 1'b0;
        wr_data = 32'h4444_0002; push_w(10'h042, 32'h4444_0002);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("rdl_done", load_done, 1'b1);
        tick();
`else
        chk("rdl_load_gnt", rd0_gnt, 1'b0);
        tick();
        wr_data = 32'h4444_0002; push_w(10'h042, 32'h4444_0002);
        @(negedge clk);
        chk("rdl_load_gnt2", rd0_gnt, 1'b0);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("rdl_done_nogrant", {load_done, rd0_gnt}, 2'b10);
        tick();
        @(negedge clk);
        chk("rdl_idle_gnt", rd0_gnt, 1'b1);
        push_r(0, 32'h4444_0000);
        tick();
        rd0_req = 1'b0;
`endif

        // Drain and confirm every expected event was seen
        repeat (3) tick();
        chk("wq_empty", wq.size(), 0);
        chk("r0q_empty", r0q.size(), 0);
        chk("r1q_empty", r1q.size(), 0);
        chk("dq_empty", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
